uart_tx_stream: RTL and testbench

//   Serial UART transmitter with a small input FIFO. Drives the SoC's ser_rx pin,
//   the host->SoC direction of the 8N1 serial link the SoC console transmits on.

---
 rtl/uart_tx_stream.sv | 105 ++++++++++
 tb/tb_uart_tx_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: 8N1 LSB-first serial transmitter fed from a small byte FIFO
module uart_tx_stream #(
  parameter int CLK_DIV    = 106,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ser_q, ser_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, last, has;
  assign tx_ready   = level_q != LW'(FIFO_DEPTH);
  assign push       = tx_valid & tx_ready;
  assign has        = level_q != '0;
  assign last       = div_q == DW'(CLK_DIV - 1);
  assign ser_tx     = ser_q;
  assign busy       = (state_q != IDLE) | has;
  assign fifo_level = level_q;
  always_comb begin
    state_d = state_q;
    div_d   = last ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (has) begin
          pop     = 1'b1;
          state_d = START;
          ser_d   = 1'b0;
          shift_d = mem_q[rd_q];
        end
      end
      START: if (last) begin
        state_d = DATA;
        ser_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (last) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          ser_d   = 1'b1;
          bit_d   = '0;
        end else begin
          ser_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
        end
      end
      STOP: if (last) begin
        // chain straight into the next start bit when a byte is waiting
        pop     = has;
        state_d = has ? START : IDLE;
        ser_d   = ~has;
        shift_d = has ? mem_q[rd_q] : shift_q;
      end
      default: state_d = IDLE;
    endcase
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed vectors and frame decoding for uart_tx_stream
module tb_uart_tx_stream;
  localparam int DIV_A = 106;
  localparam int FRAME = 10 * DIV_A;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, a_ser, a_busy, b_ready, b_ser, b_busy;
  logic [2:0] a_level, b_level;
  int         tests = 0, fails = 0, cyc = 0, saw_full = 0, bad_ready = 0;
  typedef struct {
    logic [7:0] d;
    logic [9:0] bits;
  } vec_t;
  vec_t tbl [6];
  uart_tx_stream #(.CLK_DIV(DIV_A), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .ser_tx(a_ser), .busy(a_busy), .fifo_level(a_level));
  uart_tx_stream #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .resetn(resetn), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .ser_tx(b_ser), .busy(b_busy), .fifo_level(b_level));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (a_level == 3'd4) begin
    saw_full++;
    if (a_ready) bad_ready++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_a(input logic [7:0] d);
    a_data  = d;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask
  task automatic recv_a(output logic [7:0] d, output int fall_cyc);
    int n = 0;
    d = 'x;
    while (a_ser && n < 5000) begin
      tick();
      n++;
    end
    fall_cyc = cyc;
    if (a_ser) begin
      check("recv_timeout", 32'd1, 32'd0);
      return;
    end
    repeat (DIV_A / 2) tick();
    check("start_bit", a_ser, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV_A) tick();
      d[i] = a_ser;
    end
    repeat (DIV_A) tick();
    check("stop_bit", a_ser, 1'b1);
  endtask
  initial begin
    logic [7:0] got [7];
    int         fc [7];
    logic [7:0] msg [7];
    logic [7:0] t5 [6];
    logic [9:0] exp1, bits;
    int         n, lows;
    tbl[0] = '{8'hA3, 10'b1101000110};
    tbl[1] = '{8'h55, 10'b1010101010};
    tbl[2] = '{8'h00, 10'b1000000000};
    tbl[3] = '{8'hFF, 10'b1111111110};
    tbl[4] = '{8'h01, 10'b1000000010};
    tbl[5] = '{8'h80, 10'b1100000000};
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0A};
    t5  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h77};
    tick();
    tick();
    check("rst_ser", a_ser, 1'b1);
    check("rst_ready", a_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_level", a_level, 3'd0);
    resetn = 1'b1;
    tick();
    // single 'U' frame, bit-exact and busy timing
    push_a(8'h55);
    check("t1_level_push", a_level, 3'd1);
    check("t1_busy_push", a_busy, 1'b1);
    check("t1_ser_push", a_ser, 1'b1);
    tick();
    check("t1_ser_pop", a_ser, 1'b0);
    check("t1_level_pop", a_level, 3'd0);
    exp1 = 10'b1010101010;
    repeat (DIV_A / 2) tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1_bit%0d", k), a_ser, exp1[k]);
      if (k < 9) repeat (DIV_A) tick();
    end
    repeat (FRAME - 1 - (DIV_A / 2 + 9 * DIV_A)) tick();
    check("t1_busy_last", a_busy, 1'b1);
    tick();
    check("t1_busy_end", a_busy, 1'b0);
    check("t1_ser_end", a_ser, 1'b1);
    // 0x00 then 0xFF back to back
    push_a(8'h00);
    push_a(8'hFF);
    check("t2_level_pushpop", a_level, 3'd1);
    recv_a(got[0], fc[0]);
    recv_a(got[1], fc[1]);
    check("t2_byte0", got[0], 8'h00);
    check("t2_byte1", got[1], 8'hFF);
    check("t2_gap", fc[1] - fc[0], FRAME);
    repeat (DIV_A) tick();
    // stream "Hello!\n" with tx_valid held
    saw_full  = 0;
    bad_ready = 0;
    fork
      begin
        a_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
          a_data = msg[i];
          n = 0;
          while (!a_ready && n < 5000) begin
            tick();
            n++;
          end
          if (!a_ready) check("t3_push_timeout", 32'd1, 32'd0);
          tick();
        end
        a_valid = 1'b0;
        a_data  = 8'h00;
      end
      for (int i = 0; i < 7; i++) recv_a(got[i], fc[i]);
    join
    for (int i = 0; i < 7; i++) check($sformatf("t3_byte%0d", i), got[i], msg[i]);
    check("t3_total", fc[6] - fc[0], 6 * FRAME);
    check("t3_saw_full", saw_full != 0, 1'b1);
    check("t3_ready_when_full", bad_ready, 0);
    repeat (DIV_A) tick();
    check("t3_idle", a_busy, 1'b0);
    // reset in the middle of a frame with 3 bytes queued
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    check("t4_level", a_level, 3'd3);
    repeat (500 - 2) tick();
    check("t4_ser_low", a_ser, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t4_ser", a_ser, 1'b1);
    check("t4_level0", a_level, 3'd0);
    check("t4_busy", a_busy, 1'b0);
    check("t4_ready", a_ready, 1'b1);
    lows = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (!a_ser) lows++;
    end
    check("t4_no_frames", lows, 0);
    // push while full, then push+pop at a stop-bit end
    fork
      for (int i = 0; i < 6; i++) recv_a(got[i], fc[i]);
      begin
        for (int i = 0; i < 5; i++) push_a(t5[i]);
        check("t5_full", a_level, 3'd4);
        a_data  = 8'hEE;
        a_valid = 1'b1;
        repeat (20) tick();
        a_valid = 1'b0;
        check("t5_reject_level", a_level, 3'd4);
        check("t5_reject_ready", a_ready, 1'b0);
        n = 0;
        while (a_level != 3'd3 && n < 5000) begin
          tick();
          n++;
        end
        check("t5_drain", a_level, 3'd3);
        repeat (FRAME - 1) tick();
        a_data  = 8'h77;
        a_valid = 1'b1;
        check("t5_ready_pre", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        check("t5_level_pushpop", a_level, 3'd3);
      end
    join
    for (int i = 0; i < 6; i++) check($sformatf("t5_byte%0d", i), got[i], t5[i]);
    repeat (DIV_A) tick();
    check("t5_idle", a_busy, 1'b0);
    // CLK_DIV=2 bit-exact frames
    for (int v = 0; v < 6; v++) begin
      b_data  = tbl[v].d;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
        bits[k] = b_ser;
        tick();
        tick();
      end
      check($sformatf("t6_frame_%02h", tbl[v].d), bits, tbl[v].bits);
      check($sformatf("t6_idle_%02h", tbl[v].d), b_busy, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
